// File: rtl/mt2015_q4_pkg.sv
// mt2015_q4_pkg
//   Shared definitions for the q4 lane pipeline.
//   - mode_e  : per-beat function select (Q4, A_ONLY, B_ONLY, AND)
//   - fa/fb   : per-lane partial terms A = (x^y)&x, B = ~(x^y)
//   - combine : folds A/B into the lane result for a given mode
package mt2015_q4_pkg;

  typedef enum logic [1:0] {
    Q4     = 2'd0,
    A_ONLY = 2'd1,
    B_ONLY = 2'd2,
    AND    = 2'd3
  } mode_e;

  function automatic logic fa(input logic xb, input logic yb);
    return (xb ^ yb) & xb;
  endfunction

  function automatic logic fb(input logic xb, input logic yb);
    return ~(xb ^ yb);
  endfunction

  // AND mode is always 0 because A and B are mutually exclusive; it is
  // still a legal select.
  function automatic logic combine(input mode_e m, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (m)
      Q4:      r = (a | b) ^ (a & b);
      A_ONLY:  r = a;
      B_ONLY:  r = b;
      AND:     r = a & b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mt2015_q4_pipe_popcount.sv
// mt2015_q4_pipe_popcount
//   Combinational population count of a W-bit vector.
//   Ports:
//     bits : input  [W-1:0]            vector to count
//     ones : output [$clog2(W+1)-1:0]  number of set bits in bits
module mt2015_q4_pipe_popcount
  import mt2015_q4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]             bits,
  output logic [$clog2(W+1)-1:0]   ones
);

  localparam int OW = $clog2(W + 1);

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + OW'(bits[i]);
    end
  end

endmodule

// File: rtl/mt2015_q4_pipe.sv
// mt2015_q4_pipe
//   Two-stage valid/ready pipeline evaluating the q4 network on LANES
//   independent x/y bit pairs, with per-beat mode select, a popcount of
//   each result and a saturating count of delivered beats.
//   Ports:
//     clk       : clock, rising edge
//     areset    : asynchronous active-high reset
//     in_valid  : producer offers a beat on x/y/mode
//     in_ready  : beat accepted this cycle (never depends on in_valid)
//     mode      : function select captured with the beat
//     x, y      : per-lane operands
//     out_valid : z/z_ones hold a valid beat
//     out_ready : consumer takes the beat this cycle
//     z         : per-lane result
//     z_ones    : number of set bits in z
//     beat_cnt  : saturating count of output handshakes
module mt2015_q4_pipe
  import mt2015_q4_pkg::*;
#(
  parameter int LANES = 8,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        areset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  mode,
  input  logic [LANES-1:0]            x,
  input  logic [LANES-1:0]            y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES-1:0]            z,
  output logic [$clog2(LANES+1)-1:0]  z_ones,
  output logic [CNT_W-1:0]            beat_cnt
);

  localparam int ONES_W = $clog2(LANES + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [LANES-1:0]  a_p0, b_p0;
  logic [LANES-1:0]  a_p1, b_p1;
  mode_e             mode_p1;
  logic              vld_p1;
  logic [LANES-1:0]  z_nxt_p1;
  logic [ONES_W-1:0] ones_nxt_p1;
  logic [LANES-1:0]  z_p2;
  logic [ONES_W-1:0] ones_p2;
  logic              vld_p2;
  logic              s1_load, s2_load;

  // A stage loads when empty or when its beat leaves this cycle.
  assign s2_load  = !vld_p2 | out_ready;
  assign s1_load  = !vld_p1 | s2_load;
  assign in_ready = s1_load;

  // ---- stage 0: partial terms from the raw operands ----
  always_comb begin
    a_p0 = '0;
    b_p0 = '0;
    for (int i = 0; i < LANES; i++) begin
      a_p0[i] = fa(x[i], y[i]);
      b_p0[i] = fb(x[i], y[i]);
    end
  end

  // ---- stage 1: A, B and mode registers ----
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      vld_p1 <= 1'b0;
    end else if (s1_load) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      a_p1    <= a_p0;
      b_p1    <= b_p0;
      mode_p1 <= mode_e'(mode);
    end
  end

  always_comb begin
    z_nxt_p1 = '0;
    for (int i = 0; i < LANES; i++) begin
      z_nxt_p1[i] = combine(mode_p1, a_p1[i], b_p1[i]);
    end
  end

  mt2015_q4_pipe_popcount #(
    .W (LANES)
  ) u_popcount (
    .bits (z_nxt_p1),
    .ones (ones_nxt_p1)
  );

  // ---- stage 2: result, popcount and output valid ----
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      vld_p2  <= 1'b0;
      z_p2    <= '0;
      ones_p2 <= '0;
    end else if (s2_load) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        z_p2    <= z_nxt_p1;
        ones_p2 <= ones_nxt_p1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      beat_cnt <= '0;
    end else if (vld_p2 && out_ready) begin
      beat_cnt <= sat_inc(beat_cnt);
    end
  end

  assign out_valid = vld_p2;
  assign z         = z_p2;
  assign z_ones    = ones_p2;

endmodule

// File: tb/tb_mt2015_q4_pipe.sv
// tb_mt2015_q4_pipe
//   Directed/random bench for mt2015_q4_pipe with a scoreboard queue.
//   A second instance with CNT_W=2 shares the stimulus to exercise
//   counter saturation.
module tb_mt2015_q4_pipe;

  logic       clk = 1'b0;
  logic       areset, in_valid, out_ready;
  logic [1:0] mode;
  logic [7:0] x, y;

  logic        in_ready, out_valid;
  logic [7:0]  z;
  logic [3:0]  z_ones;
  logic [15:0] beat_cnt;

  logic        in_ready2, out_valid2;
  logic [7:0]  z2;
  logic [3:0]  z_ones2;
  logic [1:0]  beat_cnt2;

  always #5 clk = ~clk;

  mt2015_q4_pipe #(.LANES(8), .CNT_W(16)) dut (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .z_ones(z_ones), .beat_cnt(beat_cnt));

  mt2015_q4_pipe #(.LANES(8), .CNT_W(2)) dut2 (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready2),
    .mode(mode), .x(x), .y(y), .out_valid(out_valid2), .out_ready(out_ready),
    .z(z2), .z_ones(z_ones2), .beat_cnt(beat_cnt2));

  typedef struct packed {
    logic [7:0] z;
    logic [3:0] ones;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cnt_model = 0;

  function automatic logic [7:0] ref_z(input logic [1:0] m, input logic [7:0] xv,
                                       input logic [7:0] yv);
    case (m)
      2'd0:    return xv | ~yv;
      2'd1:    return xv & ~yv;
      2'd2:    return xv ~^ yv;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, entered and left just after a falling edge.
  task automatic step(input logic iv, input logic [7:0] xv, input logic [7:0] yv,
                      input logic [1:0] mv, input logic ordy, output logic acc);
    logic       take;
    exp_t       e;
    logic [7:0] r;
    in_valid  = iv;
    x         = xv;
    y         = yv;
    mode      = mv;
    out_ready = ordy;
    #1;
    acc  = iv && in_ready;
    take = out_valid && out_ready;
    if (take) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        check("z", {24'd0, z}, {24'd0, e.z});
        check("z_ones", {28'd0, z_ones}, {28'd0, e.ones});
        check("z_w2", {24'd0, z2}, {24'd0, e.z});
        check("z_ones_w2", {28'd0, z_ones2}, {28'd0, e.ones});
      end
    end
    @(posedge clk);
    if (acc) begin
      r = ref_z(mv, xv, yv);
      q.push_back('{z: r, ones: 4'($countones(r))});
    end
    if (take) cnt_model++;
    @(negedge clk);
    check("beat_cnt", {16'd0, beat_cnt}, cnt_model);
    check("beat_cnt_w2", {30'd0, beat_cnt2}, (cnt_model > 3) ? 3 : cnt_model);
  endtask

  task automatic drain();
    logic a;
    int   n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 10) begin
      step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, a);
      n++;
    end
    check("drain_done", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    int         nacc;
    logic [7:0] zhold;
    logic [3:0] ohold;

    areset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'd0; x = 8'h00; y = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_z", {24'd0, z}, 0);
    check("rst_z_ones", {28'd0, z_ones}, 0);
    check("rst_beat_cnt", {16'd0, beat_cnt}, 0);
    check("rst_in_ready_w2", {31'd0, in_ready2}, 1);
    check("rst_out_valid_w2", {31'd0, out_valid2}, 0);
    areset = 1'b0;

    // Single Q4 beat with latency check
    step(1'b1, 8'b1100_1010, 8'b1010_0110, 2'd0, 1'b1, a);
    check("t1_accept", {31'd0, a}, 1);
    check("t1_lat_stage1", {31'd0, out_valid}, 0);
    step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, a);
    check("t1_lat_stage2", {31'd0, out_valid}, 1);
    check("t1_z", {24'd0, z}, 32'hDB);
    check("t1_z_ones", {28'd0, z_ones}, 6);
    step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, a);
    check("t1_beat_cnt", {16'd0, beat_cnt}, 1);

    // Modes 1/2/3 back to back
    step(1'b1, 8'hF0, 8'hCC, 2'd1, 1'b1, a);
    step(1'b1, 8'hF0, 8'hCC, 2'd2, 1'b1, a);
    check("m1_z", {24'd0, z}, 32'h30);
    check("m1_ones", {28'd0, z_ones}, 2);
    step(1'b1, 8'hF0, 8'hCC, 2'd3, 1'b1, a);
    check("m2_z", {24'd0, z}, 32'hC3);
    check("m2_ones", {28'd0, z_ones}, 4);
    step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, a);
    check("m3_z", {24'd0, z}, 32'h00);
    check("m3_ones", {28'd0, z_ones}, 0);
    check("m3_valid", {31'd0, out_valid}, 1);
    drain();

    // 20 random beats at full rate
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, a);
      check("stream_accept", {31'd0, a}, 1);
    end
    drain();
    check("stream_beat_cnt", {16'd0, beat_cnt}, 24);

    // Backpressure: fill, hold, then release into streaming
    nacc  = 0;
    zhold = 8'h00;
    ohold = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 2'(i), 1'b0, a);
      nacc += int'(a);
      if (i == 1) begin
        zhold = z;
        ohold = z_ones;
      end
      if (i >= 2) begin
        check("stall_in_ready", {31'd0, in_ready}, 0);
        check("stall_out_valid", {31'd0, out_valid}, 1);
        check("stall_z", {24'd0, z}, {24'd0, zhold});
        check("stall_z_ones", {28'd0, z_ones}, {28'd0, ohold});
      end
    end
    check("stall_accepts", nacc, 2);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, a);
      check("resume_accept", {31'd0, a}, 1);
      check("resume_no_gap", {31'd0, out_valid}, 1);
    end
    drain();

    // Reset with both stages full
    step(1'b1, 8'h5A, 8'h3C, 2'd0, 1'b0, a);
    step(1'b1, 8'hA5, 8'hC3, 2'd1, 1'b0, a);
    check("prerst_full", {31'd0, out_valid}, 1);
    #2 areset = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    check("midrst_beat_cnt", {16'd0, beat_cnt}, 0);
    check("midrst_beat_cnt_w2", {30'd0, beat_cnt2}, 0);
    check("midrst_in_ready", {31'd0, in_ready}, 1);
    check("midrst_z", {24'd0, z}, 0);
    q.delete();
    cnt_model = 0;
    @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, a);
    check("postrst_no_spurious", {31'd0, out_valid}, 0);
    step(1'b1, 8'hF0, 8'hCC, 2'd0, 1'b1, a);
    check("postrst_lat_stage1", {31'd0, out_valid}, 0);
    step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, a);
    check("postrst_lat_stage2", {31'd0, out_valid}, 1);
    check("postrst_z", {24'd0, z}, 32'hF3);
    drain();
    check("postrst_beat_cnt", {16'd0, beat_cnt}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
